// File: rtl/spi_flash_reader_if.sv
// Request/response bundle between the SoC memory side and the SPI flash reader.
// The SoC side is the master; the reader is the slave.
interface spi_flash_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_data
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master: one 03h READ of a 32-bit word per request,
// returned little-endian (first flash byte in resp_data[7:0]).
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  spi_flash_reader_if.slave bus,
  output logic sck,
  output logic ss,
  output logic mosi,
  input  logic miso
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_q, bit_d;
  logic [31:0]   tx_q, tx_d;
  logic [31:0]   rx_q, rx_d;
  logic          sck_d, ss_d, mosi_d;
  logic          rv_q, rv_d;
  logic [31:0]   rd_q, rd_d;
  logic [31:0]   cmd;
  logic          phase_end;

  assign cmd       = {8'h03, bus.req_addr};
  assign phase_end = (div_q == DIV_LAST);

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = rv_q;
  assign bus.resp_data  = rd_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sck     <= 1'b0;
      ss      <= 1'b1;
      mosi    <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sck     <= sck_d;
      ss      <= ss_d;
      mosi    <= mosi_d;
      rv_q    <= rv_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sck_d   = sck;
    ss_d    = ss;
    mosi_d  = mosi;
    rv_d    = rv_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d = SHIFT;
          ss_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = cmd[31];
          tx_d    = {cmd[30:0], 1'b0};
          rx_d    = '0;
          bit_d   = '0;
          div_d   = '0;
        end
      end
      SHIFT: begin
        if (!phase_end) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!sck) begin
            sck_d = 1'b1;
          end else begin
            // End of a high phase: sample, then set up the next slot.
            sck_d = 1'b0;
            if (bit_q[5]) begin
              rx_d = {rx_q[30:0], miso};
            end
            if (bit_q == 6'd63) begin
              state_d = RESP;
              ss_d    = 1'b1;
              mosi_d  = 1'b0;
              bit_d   = '0;
              rv_d    = 1'b1;
              rd_d    = {rx_d[7:0], rx_d[15:8],
                         rx_d[23:16], rx_d[31:24]};
            end else begin
              bit_d  = bit_q + 6'd1;
              mosi_d = (bit_q < 6'd31) ? tx_q[31] : 1'b0;
              tx_d   = {tx_q[30:0], 1'b0};
            end
          end
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: a D=2 and a D=1 instance, each talking to
// a byte-addressed NOR flash model that decodes 03h READ from the pins.
module tb_spi_flash_reader;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][23:0]  req_addr;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [1:0][31:0]  resp_data;
  logic [1:0]        sck, ss, mosi, miso;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [int];

  function automatic logic [7:0] byte_of(input logic [23:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5c;
  endfunction

  function automatic logic [31:0] exp_word(input logic [23:0] a);
    return {byte_of(a + 24'd3), byte_of(a + 24'd2),
            byte_of(a + 24'd1), byte_of(a)};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    spi_flash_reader_if bus();
    assign bus.req_valid  = req_valid[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.resp_ready = resp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign resp_valid[g]  = bus.resp_valid;
    assign resp_data[g]   = bus.resp_data;

    spi_flash_reader #(.CLK_DIV(g == 0 ? 2 : 1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus),
      .sck   (sck[g]),
      .ss    (ss[g]),
      .mosi  (mosi[g]),
      .miso  (miso[g])
    );

    // Flash model: command+address in on rising sck, data out on falling sck.
    int          fcnt = 0;
    logic [31:0] fcap = '0;
    logic        miso_r = 1'b0;
    int          j;
    logic [7:0]  b;
    assign miso[g] = miso_r;

    always @(negedge ss[g]) begin
      fcnt = 0;
      fcap = '0;
    end

    always @(posedge sck[g]) begin
      if (ss[g] === 1'b0) begin
        if (fcnt < 32) fcap = {fcap[30:0], mosi[g]};
        fcnt++;
      end
    end

    always @(negedge sck[g]) begin
      if (ss[g] === 1'b0 && fcnt >= 32 && fcnt < 64) begin
        j = fcnt - 32;
        b = byte_of(fcap[23:0] + 24'(j / 8));
        miso_r <= b[7 - (j % 8)];
      end
    end
  end

  function automatic int edges(input int i);
    return (i == 0) ? gi[0].fcnt : gi[1].fcnt;
  endfunction

  function automatic logic [31:0] captured(input int i);
    return (i == 0) ? gi[0].fcap : gi[1].fcap;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_word(input int i, input logic [23:0] a,
                           input int hold, input bit poke);
    int d;
    int n;
    logic [31:0] exp;
    d   = (i == 0) ? 2 : 1;
    exp = exp_word(a);
    @(negedge clock);
    chk("req_ready_idle", req_ready[i], 1);
    req_valid[i] = 1'b1;
    req_addr[i]  = a;
    @(negedge clock);
    req_valid[i] = 1'b0;
    req_addr[i]  = 24'($urandom);
    chk("first_slot", {ss[i], sck[i], mosi[i]}, 3'b000);
    n = 1;
    while (resp_valid[i] !== 1'b1 && n < 140 + 128 * d) begin
      @(negedge clock);
      n++;
      chk("sck_high_ss_high", ss[i] & sck[i], 0);
      if (poke && n == 40) begin
        req_valid[i] = 1'b1;
        req_addr[i]  = ~a;
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    req_valid[i] = 1'b0;
    chk("latency", n, 1 + 128 * d);
    chk("resp_data", resp_data[i], exp);
    chk("sck_edges", edges(i), 64);
    chk("cmd_addr", captured(i), {8'h03, a});
    chk("resp_pins", {ss[i], sck[i], mosi[i]}, 3'b100);
    repeat (hold) begin
      @(negedge clock);
      chk("hold_ctrl", {resp_valid[i], req_ready[i], ss[i], sck[i]},
          4'b1010);
      chk("hold_data", resp_data[i], exp);
    end
    resp_ready[i] = 1'b1;
    @(negedge clock);
    resp_ready[i] = 1'b0;
    chk("back_idle", {resp_valid[i], req_ready[i]}, 2'b01);
  endtask

  initial begin
    int n;
    req_valid  = '0;
    resp_ready = '0;
    req_addr   = '0;
    reset      = 1'b0;
    mem[32'h000100] = 8'h11;
    mem[32'h000101] = 8'h22;
    mem[32'h000102] = 8'h33;
    mem[32'h000103] = 8'h44;
    mem[32'hFFFFFC] = 8'hA5;
    mem[32'hFFFFFD] = 8'h5A;
    mem[32'hFFFFFE] = 8'hFF;
    mem[32'hFFFFFF] = 8'h00;

    #1 reset = 1'b1;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("reset_pins", {ss[i], sck[i], mosi[i], resp_valid[i]}, 4'b1000);
      chk("reset_data", resp_data[i], 0);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_reset", req_ready, 2'b11);

    read_word(0, 24'h000100, 10, 1'b0);
    chk("known_word_d2", resp_data[0], 32'h44332211);
    read_word(1, 24'hFFFFFC, 0, 1'b0);
    chk("known_word_d1", resp_data[1], 32'h00FF5AA5);
    read_word(0, 24'h000200, 2, 1'b1);

    // Abort in the middle of bit slot 20.
    @(negedge clock);
    req_valid[0] = 1'b1;
    req_addr[0]  = 24'h123456;
    @(negedge clock);
    req_valid[0] = 1'b0;
    n = 0;
    while (edges(0) < 21 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("abort_reached_slot20", edges(0), 21);
    #2 reset = 1'b1;
    #1;
    chk("abort_pins", {ss[0], sck[0], mosi[0], resp_valid[0]}, 4'b1000);
    chk("abort_data", resp_data[0], 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("ready_after_abort", req_ready, 2'b11);
    read_word(0, 24'h000004, 1, 1'b0);

    for (int k = 0; k < 6; k++) begin
      read_word(int'($urandom_range(0, 1)), 24'($urandom),
                int'($urandom_range(0, 4)), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_reader.md
# spi_flash_reader

SPI mode-0 master that fetches one 32-bit word from a serial NOR flash with the `03h` READ command. It sits between the SoC's memory-side request port and the off-chip flash pins (`sck`, `ss`, `mosi`, `miso`). For each request it shifts out the command and a 24-bit address, shifts in 32 data bits, then returns the word in little-endian byte order. It is the initiator end of the flash slave already modelled in the SoC peripheral tree.

## Interface
- `CLK_DIV`, default 2: half-period of `sck` in `clock` cycles. Must be ≥ 1.
- `clock`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  1  read request present.
- `req_ready`  out  1  block idle and accepting a request.
- `req_addr`  in  24  flash byte address.
- `resp_valid`  out  1  `resp_data` is valid; held until `resp_ready`.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_data`  out  32  word read from flash.
- `sck`  out  1  SPI clock; idles low.
- `ss`  out  1  chip select, active-low; idles high.
- `mosi`  out  1  serial data to flash.
- `miso`  in  1  serial data from flash.

## Operation
- States:
  - IDLE: `req_ready`=1; `ss`=1, `sck`=0, `mosi`=0.
  - SHIFT: 64 bit slots.
  - RESP: `resp_valid`=1.
- Transitions:
  - IDLE→SHIFT on `req_valid && req_ready`. Latch the 32-bit shift word `{8'h03, req_addr}` and clear the bit counter (0..63).
  - SHIFT→RESP after bit slot 63 completes.
  - RESP→IDLE on `resp_ready`.
- Bits 0–31 (command, then address):
  - Driven MSB first on `mosi`.
  - Each bit is driven at the start of its low `sck` phase and held through the high phase.
- Bits 32–63:
  - `mosi`=0.
  - `miso` is sampled at the `clock` edge that ends each high phase (the same edge that drives `sck` low), then shifted into a 32-bit register MSB first.
- Byte order:
  - `resp_data = {B3, B2, B1, B0}`, where B0 is the first received byte (the byte at `req_addr`).
  - Equivalently, `resp_data` is the byte-swapped received word.
- `resp_data` is loaded on entry to RESP and is stable while `resp_valid`=1.
- No backpressure on the SPI side.
- `req_valid` outside IDLE is ignored. `req_addr` is not sampled after acceptance.
- Reset (asynchronous, at any time, including mid-transfer):
  - Outputs go immediately to `ss`=1, `sck`=0, `mosi`=0, `resp_valid`=0, `resp_data`=0.
  - The state returns to IDLE, so `req_ready`=1 once `reset` is released.
  - A partial transfer is discarded. Raising `ss` aborts the flash side.

## Timing
- Let D = `CLK_DIV`, with the request accepted at cycle T.
- T+1: `ss`=0, `sck`=0, `mosi`=bit 7 of `03h`.
- Bit k (0..63):
  - `sck` low for cycles [T+1+2kD, T+1+2kD+D).
  - `sck` high for cycles [T+1+2kD+D, T+1+2(k+1)D).
  - `mosi` changes only at low-phase starts.
- Exactly 64 `sck` rising edges per transfer.
- Cycle T+1+128D:
  - `ss`=1, `sck`=0, `resp_valid`=1.
  - Latency accept→`resp_valid` is 1+128D cycles (257 at D=2).
- `ss` stays high for ≥ 2 cycles between transfers: the RESP cycle(s) plus the IDLE accept cycle.
- `sck` is never high while `ss`=1.
- `ss` falls only while `sck`=0 and rises only after the last falling `sck`.
- `req_ready` is combinational from state. All other outputs are registered.
- Divider counter width is $clog2(CLK_DIV)+1. It reloads each phase, and the bit counter wraps 63→0 only on state exit.

## Test plan
- Reset: assert `reset` mid-cycle → `ss`=1, `sck`=0, `mosi`=0, `resp_valid`=0, `resp_data`=0 immediately; `req_ready`=1 after release.
- D=2 single read:
  - Stimulus: `req_addr`=0x000100, flash model returns bytes 11,22,33,44.
  - `mosi` sampled on `sck` rising edges equals 0x03 then 0x000100.
  - 64 `sck` edges.
  - `resp_valid` at T+257 with `resp_data`=0x44332211.
- Response backpressure: `resp_ready`=0 for 10 cycles → `resp_valid`/`resp_data` held stable, `req_ready`=0, `ss`=1, `sck`=0; `resp_ready`=1 → IDLE next cycle.
- Busy ignore: pulse `req_valid` with a different address during SHIFT → no effect; response matches the original address.
- Abort: assert `reset` at bit slot 20 → `ss` rises immediately; a new request for 0x000004 then completes with correct data.
- D=1 boundary:
  - Stimulus: `req_addr`=0xFFFFFC, flash bytes A5,5A,FF,00.
  - `sck` = `clock`/2.
  - `resp_data`=0x00FF5AA5 at T+129.
